// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and width helpers for the
// PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_LOCK_WAIT = 3'd1,
    S_DOM_REL   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } seq_state_e;

  localparam int DEF_NUM_PLL      = 2;
  localparam int DEF_NUM_DOM      = 3;
  localparam int DEF_RST_HOLD     = 16;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_DOM_GAP      = 8;
  localparam int DEF_MAX_RETRY    = 3;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // Width of an index into n items, never zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock inputs and reset/status outputs of the PLL reset sequencer.
// PLL_RESET_SEQUENCER_RELOCK_CNT_EN adds the relock_cnt status field.
interface pll_reset_sequencer_if import pll_seq_pkg::*; #(
  parameter int NUM_PLL   = DEF_NUM_PLL,
  parameter int NUM_DOM   = DEF_NUM_DOM,
  parameter int MAX_RETRY = DEF_MAX_RETRY
);

  logic [NUM_PLL-1:0]          pll_lock;
  logic [NUM_PLL-1:0]          pll_rst;
  logic [NUM_DOM-1:0]          dom_rst;
  logic                        seq_done;
  logic                        fault;
  logic [cnt_w(MAX_RETRY)-1:0] retry_cnt;

`ifdef PLL_RESET_SEQUENCER_RELOCK_CNT_EN
  logic [7:0]                  relock_cnt;

  modport master (input pll_lock,
                  output pll_rst, dom_rst, seq_done, fault, retry_cnt, relock_cnt);
  modport slave  (output pll_lock,
                  input pll_rst, dom_rst, seq_done, fault, retry_cnt, relock_cnt);
`else
  modport master (input pll_lock,
                  output pll_rst, dom_rst, seq_done, fault, retry_cnt);
  modport slave  (output pll_lock,
                  input pll_rst, dom_rst, seq_done, fault, retry_cnt);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Chained PLL bring-up, lock qualification and staged domain reset release.
// PLL_RESET_SEQUENCER_RELOCK_CNT_EN adds a saturating run-mode relock counter.
//
// state       | meaning
// S_PLL_RST   | all resets held, counting RST_HOLD
// S_LOCK_WAIT | PLLs 0..p released, qualifying lock of PLL p
// S_DOM_REL   | all PLLs locked, releasing domain resets every DOM_GAP
// S_RUN       | sequence complete, watching for lock loss
// S_FAULT     | retries exhausted, everything held until rst
module pll_reset_sequencer import pll_seq_pkg::*; #(
  parameter int NUM_PLL      = DEF_NUM_PLL,
  parameter int NUM_DOM      = DEF_NUM_DOM,
  parameter int RST_HOLD     = DEF_RST_HOLD,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int DOM_GAP      = DEF_DOM_GAP,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input logic                   clk_in,
  input logic                   rst,
  pll_reset_sequencer_if.master bus
);

  localparam int HW = cnt_w(RST_HOLD);
  localparam int SW = cnt_w(LOCK_STABLE);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int GW = cnt_w(DOM_GAP);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int PW = idx_w(NUM_PLL);
  localparam int DW = idx_w(NUM_DOM);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(DOM_GAP - 1);
  localparam logic [RW-1:0] R_MAX     = RW'(MAX_RETRY);
  localparam logic [PW-1:0] P_LAST    = PW'(NUM_PLL - 1);
  localparam logic [DW-1:0] D_LAST    = DW'(NUM_DOM - 1);

  logic [NUM_PLL-1:0] lk;

  sync_2ff #(.WIDTH(NUM_PLL)) u_lock_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (bus.pll_lock),
    .q   (lk)
  );

  seq_state_e         state_q, state_n;
  logic [PW-1:0]      p_q, p_n;
  logic [DW-1:0]      d_q, d_n;
  logic [HW-1:0]      hold_q, hold_n;
  logic [SW-1:0]      stab_q, stab_n;
  logic [TW-1:0]      to_q, to_n;
  logic [GW-1:0]      gap_q, gap_n;
  logic [RW-1:0]      retry_q, retry_n, retry_inc;
  logic [NUM_PLL-1:0] pll_rst_q, pll_rst_n;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_n;
  logic               seq_done_q, fault_q;
  logic               lower_lost, fail;

  assign retry_inc = (retry_q == R_MAX) ? retry_q : retry_q + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= S_PLL_RST;
      p_q        <= '0;
      d_q        <= '0;
      hold_q     <= '0;
      stab_q     <= '0;
      to_q       <= '0;
      gap_q      <= '0;
      retry_q    <= '0;
      pll_rst_q  <= '1;
      dom_rst_q  <= '1;
      seq_done_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      p_q        <= p_n;
      d_q        <= d_n;
      hold_q     <= hold_n;
      stab_q     <= stab_n;
      to_q       <= to_n;
      gap_q      <= gap_n;
      retry_q    <= retry_n;
      pll_rst_q  <= pll_rst_n;
      dom_rst_q  <= dom_rst_n;
      seq_done_q <= (state_n == S_RUN);
      fault_q    <= (state_n == S_FAULT);
    end
  end

  always_comb begin
    state_n    = state_q;
    p_n        = p_q;
    d_n        = d_q;
    hold_n     = hold_q;
    stab_n     = stab_q;
    to_n       = to_q;
    gap_n      = gap_q;
    retry_n    = retry_q;
    dom_rst_n  = dom_rst_q;
    lower_lost = 1'b0;
    fail       = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        dom_rst_n = '1;
        if (hold_q == HOLD_LAST) begin
          state_n = S_LOCK_WAIT;
          p_n     = '0;
          hold_n  = '0;
          stab_n  = '0;
          to_n    = '0;
        end else begin
          hold_n = hold_q + 1'b1;
        end
      end

      S_LOCK_WAIT: begin
        dom_rst_n = '1;
        for (int j = 0; j < NUM_PLL; j++) begin
          if ((j < int'(p_q)) && !lk[j]) lower_lost = 1'b1;
        end
        fail = lower_lost || (to_q == TO_LAST);
        // Failure is checked first so it wins over a same-cycle qualification.
        if (fail) begin
          retry_n = retry_inc;
          state_n = (retry_inc == R_MAX) ? S_FAULT : S_PLL_RST;
          hold_n  = '0;
        end else if (lk[p_q]) begin
          if (stab_q == STAB_LAST) begin
            stab_n = '0;
            to_n   = '0;
            if (p_q == P_LAST) begin
              state_n = S_DOM_REL;
              d_n     = '0;
              gap_n   = '0;
            end else begin
              p_n = p_q + 1'b1;
            end
          end else begin
            stab_n = stab_q + 1'b1;
            to_n   = to_q + 1'b1;
          end
        end else begin
          stab_n = '0;
          to_n   = to_q + 1'b1;
        end
      end

      S_DOM_REL: begin
        if (!(&lk)) begin
          dom_rst_n = '1;
          retry_n   = retry_inc;
          state_n   = (retry_inc == R_MAX) ? S_FAULT : S_PLL_RST;
          hold_n    = '0;
        end else if (gap_q == GAP_LAST) begin
          dom_rst_n[d_q] = 1'b0;
          gap_n          = '0;
          if (d_q == D_LAST) begin
            state_n = S_RUN;
            retry_n = '0;
          end else begin
            d_n = d_q + 1'b1;
          end
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end

      S_RUN: begin
        if (!(&lk)) begin
          dom_rst_n = '1;
          state_n   = S_PLL_RST;
          hold_n    = '0;
          retry_n   = '0;
        end
      end

      S_FAULT: begin
        dom_rst_n = '1;
      end

      default: begin
        state_n   = S_PLL_RST;
        hold_n    = '0;
        dom_rst_n = '1;
      end
    endcase
  end

  // PLL resets follow the next state so they are registered with it.
  always_comb begin
    pll_rst_n = '1;
    case (state_n)
      S_LOCK_WAIT: begin
        for (int j = 0; j < NUM_PLL; j++) pll_rst_n[j] = (j > int'(p_n));
      end
      S_DOM_REL, S_RUN: pll_rst_n = '0;
      default:          pll_rst_n = '1;
    endcase
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.dom_rst   = dom_rst_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_RESET_SEQUENCER_RELOCK_CNT_EN
  logic [7:0] relock_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      relock_q <= '0;
    end else if ((state_q == S_RUN) && (state_n == S_PLL_RST) && (relock_q != 8'hFF)) begin
      relock_q <= relock_q + 1'b1;
    end
  end

  assign bus.relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table for the nominal
// bring-up and run-mode relock, hand sequences for the multi-cycle corners.
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pll_reset_sequencer_if #(.NUM_PLL(2), .NUM_DOM(3), .MAX_RETRY(3)) bus ();

  pll_reset_sequencer #(
    .NUM_PLL      (2),
    .NUM_DOM      (3),
    .RST_HOLD     (4),
    .LOCK_STABLE  (4),
    .LOCK_TIMEOUT (32),
    .DOM_GAP      (2),
    .MAX_RETRY    (3)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0] delta;
    logic [1:0] lock;
    logic [8:0] exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;
  int held;

  function automatic logic [8:0] pk(input logic [1:0] pr, input logic [2:0] dr,
                                    input logic sd, input logic ft, input logic [1:0] rc);
    return {pr, dr, sd, ft, rc};
  endfunction

  function automatic vec_t mk(input int delta, input logic [1:0] lock,
                              input logic [1:0] pr, input logic [2:0] dr, input logic sd);
    return {8'(delta), lock, pk(pr, dr, sd, 1'b0, 2'd0)};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.pll_rst, bus.dom_rst, bus.seq_done, bus.fault, bus.retry_cnt};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got pll_rst=%b dom_rst=%b done=%b fault=%b retry=%0d, want pll_rst=%b dom_rst=%b done=%b fault=%b retry=%0d",
               name, got[8:7], got[6:4], got[3], got[2], got[1:0],
               exp[8:7], exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset for three edges, then release it with the given lock pattern.
  task automatic start(input logic [1:0] lock);
    rst = 1'b1;
    bus.pll_lock = 2'b00;
    step(3);
    rst = 1'b0;
    bus.pll_lock = lock;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.pll_lock = 2'b00;

    // Edge counts are from reset release; lock held at 11 unless noted.
    vecs[0]  = mk(3,  2'b11, 2'b11, 3'b111, 1'b0);
    vecs[1]  = mk(1,  2'b11, 2'b10, 3'b111, 1'b0);
    vecs[2]  = mk(3,  2'b11, 2'b10, 3'b111, 1'b0);
    vecs[3]  = mk(1,  2'b11, 2'b00, 3'b111, 1'b0);
    vecs[4]  = mk(4,  2'b11, 2'b00, 3'b111, 1'b0);
    vecs[5]  = mk(1,  2'b11, 2'b00, 3'b111, 1'b0);
    vecs[6]  = mk(1,  2'b11, 2'b00, 3'b110, 1'b0);
    vecs[7]  = mk(1,  2'b11, 2'b00, 3'b110, 1'b0);
    vecs[8]  = mk(1,  2'b11, 2'b00, 3'b100, 1'b0);
    vecs[9]  = mk(1,  2'b11, 2'b00, 3'b100, 1'b0);
    vecs[10] = mk(1,  2'b11, 2'b00, 3'b000, 1'b1);
    vecs[11] = mk(2,  2'b11, 2'b00, 3'b000, 1'b1);
    vecs[12] = mk(2,  2'b10, 2'b00, 3'b000, 1'b1);
    vecs[13] = mk(1,  2'b10, 2'b11, 3'b111, 1'b0);
    vecs[14] = mk(4,  2'b11, 2'b10, 3'b111, 1'b0);
    vecs[15] = mk(3,  2'b11, 2'b10, 3'b111, 1'b0);
    vecs[16] = mk(1,  2'b11, 2'b00, 3'b111, 1'b0);
    vecs[17] = mk(10, 2'b11, 2'b00, 3'b000, 1'b1);

    step(2);
    check("reset", outs(), pk(2'b11, 3'b111, 1'b0, 1'b0, 2'd0));

    start(2'b11);
    for (int i = 0; i < NVEC; i++) begin
      bus.pll_lock = vecs[i].lock;
      step(int'(vecs[i].delta));
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
`ifdef PLL_RESET_SEQUENCER_RELOCK_CNT_EN
    check_val("relock_cnt", int'(bus.relock_cnt), 1);
`endif

    // Chain order: PLL1 locked early, PLL0 only after 20 cycles.
    start(2'b10);
    held = 1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 21) bus.pll_lock = 2'b11;
      step(1);
      if (bus.pll_rst[1] !== 1'b1) held = 0;
    end
    check_val("chain_pll1_held", held, 1);
    check("chain_e25", outs(), pk(2'b10, 3'b111, 1'b0, 1'b0, 2'd0));
    step(1);
    check("chain_e26", outs(), pk(2'b00, 3'b111, 1'b0, 1'b0, 2'd0));

    // One-cycle lock glitch after two stable counts restarts qualification.
    start(2'b11);
    step(4);
    bus.pll_lock = 2'b10;
    step(1);
    bus.pll_lock = 2'b11;
    step(3);
    check("glitch_e8", outs(), pk(2'b10, 3'b111, 1'b0, 1'b0, 2'd0));
    step(2);
    check("glitch_e10", outs(), pk(2'b10, 3'b111, 1'b0, 1'b0, 2'd0));
    step(1);
    check("glitch_e11", outs(), pk(2'b00, 3'b111, 1'b0, 1'b0, 2'd0));

    // PLL1 never locks: three timeouts then sticky fault.
    start(2'b01);
    step(39);
    check("to_e39", outs(), pk(2'b00, 3'b111, 1'b0, 1'b0, 2'd0));
    step(1);
    check("to_e40", outs(), pk(2'b11, 3'b111, 1'b0, 1'b0, 2'd1));
    step(39);
    check("to_e79", outs(), pk(2'b00, 3'b111, 1'b0, 1'b0, 2'd1));
    step(1);
    check("to_e80", outs(), pk(2'b11, 3'b111, 1'b0, 1'b0, 2'd2));
    step(39);
    check("to_e119", outs(), pk(2'b00, 3'b111, 1'b0, 1'b0, 2'd2));
    step(1);
    check("fault_e120", outs(), pk(2'b11, 3'b111, 1'b0, 1'b1, 2'd3));
    bus.pll_lock = 2'b11;
    step(50);
    check("fault_sticky", outs(), pk(2'b11, 3'b111, 1'b0, 1'b1, 2'd3));
    rst = 1'b1;
    step(1);
    check("fault_cleared", outs(), pk(2'b11, 3'b111, 1'b0, 1'b0, 2'd0));

    // Reset in the middle of domain release.
    start(2'b11);
    step(15);
    check("domrel_mid", outs(), pk(2'b00, 3'b110, 1'b0, 1'b0, 2'd0));
    rst = 1'b1;
    step(1);
    check("domrel_rst", outs(), pk(2'b11, 3'b111, 1'b0, 1'b0, 2'd0));
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
